bus_register: RTL

// - Parametrised successor of the 12-bit dual-output latch: WIDTH-bit register plus 1-bit link,

---
 rtl/bus_register_pkg.sv | 17 +
 rtl/bus_tap.sv | 20 ++
 rtl/bus_register.sv | 112 +++++++++++
 3 files changed

// File: rtl/bus_register_pkg.sv
// Shared op codes, FSM state and rotate-direction types for bus_register.
package bus_register_pkg;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_RAL  = 3'd4;
  localparam logic [2:0] OP_RAR  = 3'd5;
  localparam logic [2:0] OP_RTL  = 3'd6;
  localparam logic [2:0] OP_RTR  = 3'd7;

  typedef enum logic {ST_IDLE = 1'b0, ST_ROT2 = 1'b1} state_e;

  typedef enum logic {ROT_LEFT = 1'b0, ROT_RIGHT = 1'b1} rot_dir_e;

endpackage

// File: rtl/bus_tap.sv
// One enable-gated output tap; a disabled tap floats or drives zero.
module bus_tap #(
  parameter int WIDTH    = 12,
  parameter bit TRISTATE = 1'b1
) (
  input  logic             oe_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] out_o
);

  generate
    if (TRISTATE) begin : g_tri
      assign out_o = oe_i ? d_i : {WIDTH{1'bz}};
    end else begin : g_or
      // Zero when disabled so several taps can be OR-ed onto one bus.
      assign out_o = oe_i ? d_i : '0;
    end
  endgenerate

endmodule

// File: rtl/bus_register.sv
// WIDTH-bit register with link bit, op-code datapath, two-cycle rotate FSM and NOUT output taps.
module bus_register
  import bus_register_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int NOUT     = 2,
  parameter bit TRISTATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  link_in,
  input  logic [2:0]            op,
  input  logic [NOUT-1:0]       oe,
  output logic [NOUT*WIDTH-1:0] out,
  output logic [WIDTH-1:0]      q,
  output logic                  link,
  output logic                  zero,
  output logic                  busy
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             link_q, link_d;
  state_e           state_q, state_d;
  rot_dir_e         dir_q, dir_d;

  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   rot_l;
  logic [WIDTH:0]   rot_r;

  // Rotations act on the WIDTH+1 bit word {link, q}.
  assign inc_sum = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
  assign rot_l   = {q_q, link_q};
  assign rot_r   = {q_q[0], link_q, q_q[WIDTH-1:1]};

  always_comb begin
    q_d     = q_q;
    link_d  = link_q;
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        case (op)
          OP_LOAD: begin
            q_d    = in;
            link_d = link_in;
          end
          OP_CLR: begin
            q_d    = '0;
            link_d = 1'b0;
          end
          OP_INC: begin
            q_d    = inc_sum[WIDTH-1:0];
            link_d = link_q ^ inc_sum[WIDTH];
          end
          OP_RAL: {link_d, q_d} = rot_l;
          OP_RAR: {link_d, q_d} = rot_r;
          OP_RTL: begin
            {link_d, q_d} = rot_l;
            state_d       = ST_ROT2;
            dir_d         = ROT_LEFT;
          end
          OP_RTR: begin
            {link_d, q_d} = rot_r;
            state_d       = ST_ROT2;
            dir_d         = ROT_RIGHT;
          end
          default: ;
        endcase
      end
      ST_ROT2: begin
        // Second half of a double rotate; op is ignored here.
        {link_d, q_d} = (dir_q == ROT_LEFT) ? rot_l : rot_r;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      link_q  <= 1'b0;
      state_q <= ST_IDLE;
      dir_q   <= ROT_LEFT;
    end else begin
      q_q     <= q_d;
      link_q  <= link_d;
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign q    = q_q;
  assign link = link_q;
  assign zero = (q_q == '0);
  assign busy = (state_q == ST_ROT2);

  generate
    for (genvar i = 0; i < NOUT; i++) begin : g_tap
      bus_tap #(
        .WIDTH   (WIDTH),
        .TRISTATE(TRISTATE)
      ) u_tap (
        .oe_i (oe[i]),
        .d_i  (q_q),
        .out_o(out[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule
